// File: rtl/ts_out_proxy.sv
// rtl/ts_out_proxy.sv - EP2 OUT buffer to 188-byte serial TS output proxy
// Fetch FSM re-aligns buffer bytes on the sync byte; serializer shifts them out MSB first.
module ts_out_proxy #(
  parameter int         CLK_DIV     = 2,
  parameter int         PKT_LEN     = 188,
  parameter logic [7:0] SYNC_BYTE   = 8'h47,
  parameter int         REL_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        ep2_usb_out_has_data,
  input  logic [10:0] ep2_usb_out_len,
  output logic [10:0] ep2_usb_out_addr,
  input  logic [7:0]  ep2_usb_out_data,
  output logic        ep2_usb_out_arm,
  output logic        ts_clock,
  output logic        ts_start,
  output logic        ts_valid,
  output logic        ts_data,
  output logic [15:0] pkt_sent,
  output logic [8:0]  sync_lost,
  output logic [8:0]  underrun,
  output logic [8:0]  rel_timeout
);
  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int IDX_W = $clog2(PKT_LEN);
  localparam int RT_W  = $clog2(REL_TIMEOUT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN - 1);
  localparam logic [RT_W-1:0]  RT_LAST  = RT_W'(REL_TIMEOUT - 1);

  typedef enum logic [2:0] {F_IDLE, F_READ, F_LATCH, F_HOLD, F_ARM, F_RELEASE} fstate_t;

  fstate_t          fstate_q, fstate_d;
  logic [10:0]      addr_q, addr_d, addr_next;
  logic [IDX_W-1:0] fidx_q, fidx_d;
  logic [7:0]       carry_q, carry_d;
  logic             carry_last_q, carry_last_d;
  logic [RT_W-1:0]  rel_cnt_q, rel_cnt_d;
  logic [7:0]       hold_byte_q, hold_byte_d;
  logic             hold_valid_q, hold_valid_d;
  logic [8:0]       sync_lost_q, sync_lost_d;
  logic [8:0]       rel_to_q, rel_to_d;
  logic             arm;

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic             in_pkt_q, in_pkt_d;
  logic [IDX_W-1:0] sidx_q, sidx_d;
  logic             last_byte_q, last_byte_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d, start_q, start_d, data_q, data_d;
  logic [15:0]      pkt_sent_q, pkt_sent_d;
  logic [8:0]       underrun_q, underrun_d;
  logic             run, consume, pkt_open;

  assign run              = enable | in_pkt_q;
  assign ts_clock         = (div_q >= DIV_HALF);
  assign ts_valid         = valid_q;
  assign ts_start         = start_q;
  assign ts_data          = data_q;
  assign pkt_sent         = pkt_sent_q;
  assign sync_lost        = sync_lost_q;
  assign underrun         = underrun_q;
  assign rel_timeout      = rel_to_q;
  assign ep2_usb_out_addr = addr_q;
  assign ep2_usb_out_arm  = arm;

  always_comb begin
    div_d       = div_q;
    bit_d       = bit_q;
    in_pkt_d    = in_pkt_q;
    sidx_d      = sidx_q;
    last_byte_d = last_byte_q;
    shift_d     = shift_q;
    valid_d     = valid_q;
    start_d     = start_q;
    data_d      = data_q;
    pkt_sent_d  = pkt_sent_q;
    underrun_d  = underrun_q;
    consume     = 1'b0;
    pkt_open    = 1'b0;
    if (!run) begin
      div_d = '0;
    end else begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      if (div_q == DIV_LAST) begin
        if (in_pkt_q && bit_q != 3'd7) begin
          bit_d   = bit_q + 3'd1;
          data_d  = shift_q[6];
          shift_d = {shift_q[6:0], 1'b0};
        end else begin
          // Slot boundary; between packets every bit period is a candidate start.
          bit_d    = '0;
          pkt_open = in_pkt_q & ~last_byte_q;
          if (in_pkt_q && last_byte_q) pkt_sent_d = pkt_sent_q + 16'd1;
          if (hold_valid_q && (pkt_open || enable)) begin
            consume     = 1'b1;
            in_pkt_d    = 1'b1;
            shift_d     = hold_byte_q;
            data_d      = hold_byte_q[7];
            valid_d     = 1'b1;
            start_d     = (sidx_q == '0);
            last_byte_d = (sidx_q == IDX_LAST);
            sidx_d      = (sidx_q == IDX_LAST) ? '0 : sidx_q + IDX_W'(1);
          end else begin
            in_pkt_d    = pkt_open;
            shift_d     = '0;
            data_d      = 1'b0;
            valid_d     = 1'b0;
            start_d     = 1'b0;
            last_byte_d = 1'b0;
            if (pkt_open && underrun_q != '1) underrun_d = underrun_q + 9'd1;
          end
        end
      end
    end
  end

  always_comb begin
    fstate_d     = fstate_q;
    addr_d       = addr_q;
    addr_next    = addr_q + 11'd1;
    fidx_d       = fidx_q;
    carry_d      = carry_q;
    carry_last_d = carry_last_q;
    rel_cnt_d    = rel_cnt_q;
    hold_byte_d  = hold_byte_q;
    hold_valid_d = hold_valid_q & ~consume;
    sync_lost_d  = sync_lost_q;
    rel_to_d     = rel_to_q;
    arm          = 1'b0;
    case (fstate_q)
      F_IDLE: begin
        addr_d = '0;
        if (ep2_usb_out_has_data) fstate_d = (ep2_usb_out_len != '0) ? F_READ : F_ARM;
      end
      F_READ: fstate_d = F_LATCH;
      F_LATCH: begin
        addr_d = addr_next;
        if (fidx_q == '0 && ep2_usb_out_data != SYNC_BYTE) begin
          if (sync_lost_q != '1) sync_lost_d = sync_lost_q + 9'd1;
          fstate_d = (addr_next == ep2_usb_out_len) ? F_ARM : F_READ;
        end else begin
          carry_d      = ep2_usb_out_data;
          carry_last_d = (addr_next == ep2_usb_out_len);
          fstate_d     = F_HOLD;
        end
      end
      F_HOLD: begin
        // A load may coincide with the serializer taking the previous byte.
        if (!hold_valid_q || consume) begin
          hold_byte_d  = carry_q;
          hold_valid_d = 1'b1;
          fidx_d       = (fidx_q == IDX_LAST) ? '0 : fidx_q + IDX_W'(1);
          fstate_d     = carry_last_q ? F_ARM : F_READ;
        end
      end
      F_ARM: begin
        arm       = 1'b1;
        addr_d    = '0;
        rel_cnt_d = '0;
        fstate_d  = F_RELEASE;
      end
      F_RELEASE: begin
        if (!ep2_usb_out_has_data) begin
          fstate_d = F_IDLE;
        end else if (rel_cnt_q == RT_LAST) begin
          if (rel_to_q != '1) rel_to_d = rel_to_q + 9'd1;
          fstate_d = F_IDLE;
        end else begin
          rel_cnt_d = rel_cnt_q + RT_W'(1);
        end
      end
      default: fstate_d = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fstate_q     <= F_IDLE;
      addr_q       <= '0;
      fidx_q       <= '0;
      carry_q      <= '0;
      carry_last_q <= 1'b0;
      rel_cnt_q    <= '0;
      hold_byte_q  <= '0;
      hold_valid_q <= 1'b0;
      sync_lost_q  <= '0;
      rel_to_q     <= '0;
      div_q        <= '0;
      bit_q        <= '0;
      in_pkt_q     <= 1'b0;
      sidx_q       <= '0;
      last_byte_q  <= 1'b0;
      shift_q      <= '0;
      valid_q      <= 1'b0;
      start_q      <= 1'b0;
      data_q       <= 1'b0;
      pkt_sent_q   <= '0;
      underrun_q   <= '0;
    end else begin
      fstate_q     <= fstate_d;
      addr_q       <= addr_d;
      fidx_q       <= fidx_d;
      carry_q      <= carry_d;
      carry_last_q <= carry_last_d;
      rel_cnt_q    <= rel_cnt_d;
      hold_byte_q  <= hold_byte_d;
      hold_valid_q <= hold_valid_d;
      sync_lost_q  <= sync_lost_d;
      rel_to_q     <= rel_to_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      in_pkt_q     <= in_pkt_d;
      sidx_q       <= sidx_d;
      last_byte_q  <= last_byte_d;
      shift_q      <= shift_d;
      valid_q      <= valid_d;
      start_q      <= start_d;
      data_q       <= data_d;
      pkt_sent_q   <= pkt_sent_d;
      underrun_q   <= underrun_d;
    end
  end
endmodule
